// File: rtl/up_counter_top.sv
// up_counter_top
// Free-running 16-bit binary + 4-digit BCD up counter, advanced together by an
// enable-gated prescaler, driving an 8-digit multiplexed seven-segment display.
// Digits 0..3 show the selected count (sel=0 hex of binary, sel=1 BCD).
// Build option: define SECONDARY_DISPLAY_EN to light digits 4..7 with the
// non-selected count; when undefined those digits stay blank.
// All outputs are registered (one cycle behind index/count state).

module up_counter_top #(
    parameter int SIZE     = 27,   // prescaler width, one step per 2^SIZE enabled cycles
    parameter int SCAN_DIV = 17    // scan divider width, 0 = advance digit every cycle
) (
    input  logic       top_port_clk,
    input  logic       top_port_rst,
    input  logic       top_port_en,
    input  logic       top_port_sel,
    input  logic       top_port_idp,
    output logic [6:0] top_port_ssd,
    output logic       top_port_odp,
    output logic [7:0] top_port_an
);

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // Decimal increment of a 4-digit packed BCD value; 9999 rolls to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] val);
        logic [15:0] res;
        logic        carry;
        res   = val;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (val[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                    carry         = 1'b1;
                end else begin
                    res[i*4 +: 4] = val[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[i*4 +: 4] = val[i*4 +: 4];
            end
        end
        return res;
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler and counts
    // ------------------------------------------------------------------
    logic [SIZE-1:0] presc_r;
    logic [15:0]     bin_r;
    logic [15:0]     bcd_r;
    logic            tick_s;

    // A count step happens on the enabled cycle where the prescaler is at its top value.
    assign tick_s = top_port_en & (presc_r == {SIZE{1'b1}});

    // Prescaler: free-wrapping while enabled, frozen otherwise.
    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            presc_r <= {SIZE{1'b0}};
        end else if (top_port_en) begin
            presc_r <= presc_r + SIZE'(1);
        end else begin
            presc_r <= presc_r;
        end
    end

    // Binary and BCD counts advance together on the same tick so they never drift apart.
    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            bin_r <= 16'h0000;
            bcd_r <= 16'h0000;
        end else if (tick_s) begin
            bin_r <= bin_r + 16'd1;
            bcd_r <= bcd_inc(bcd_r);
        end else begin
            bin_r <= bin_r;
            bcd_r <= bcd_r;
        end
    end

    // ------------------------------------------------------------------
    // Digit scan: divider plus 3-bit digit index
    // ------------------------------------------------------------------
    logic       scan_wrap_s;
    logic [2:0] idx_r;

    generate
        if (SCAN_DIV == 0) begin : g_no_scan_div
            assign scan_wrap_s = 1'b1;
        end else begin : g_scan_div
            logic [SCAN_DIV-1:0] scan_div_r;

            // Scan divider runs every cycle regardless of count enable.
            always_ff @(posedge top_port_clk) begin
                if (top_port_rst) begin
                    scan_div_r <= {SCAN_DIV{1'b0}};
                end else begin
                    scan_div_r <= scan_div_r + SCAN_DIV'(1);
                end
            end

            assign scan_wrap_s = (scan_div_r == {SCAN_DIV{1'b1}});
        end
    endgenerate

    // Digit index steps 0..7 each time the scan divider wraps.
    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            idx_r <= 3'd0;
        end else if (scan_wrap_s) begin
            idx_r <= idx_r + 3'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    // ------------------------------------------------------------------
    // Display selection
    // ------------------------------------------------------------------
    logic [15:0] pri_s;
    logic [3:0]  nib_s;
    logic        lit_s;
    logic [7:0]  an_nxt_s;
    logic [6:0]  ssd_nxt_s;
    logic        odp_nxt_s;
`ifdef SECONDARY_DISPLAY_EN
    logic [15:0] sec_s;
`endif

    // Pick the nibble for the current digit and build the next anode/segment/dp values.
    always_comb begin
        pri_s     = 16'h0000;
        nib_s     = 4'h0;
        lit_s     = 1'b0;
        an_nxt_s  = 8'hFF;
        ssd_nxt_s = 7'h7F;
        odp_nxt_s = 1'b1;
`ifdef SECONDARY_DISPLAY_EN
        sec_s     = 16'h0000;
`endif

        if (top_port_sel) begin
            pri_s = bcd_r;
        end else begin
            pri_s = bin_r;
        end

`ifdef SECONDARY_DISPLAY_EN
        // Upper digits carry whichever count is not selected for the lower digits.
        if (top_port_sel) begin
            sec_s = bin_r;
        end else begin
            sec_s = bcd_r;
        end
        lit_s = 1'b1;
        if (idx_r[2]) begin
            nib_s = sec_s[{idx_r[1:0], 2'b00} +: 4];
        end else begin
            nib_s = pri_s[{idx_r[1:0], 2'b00} +: 4];
        end
`else
        // Upper digits are blank in this build.
        lit_s = ~idx_r[2];
        nib_s = pri_s[{idx_r[1:0], 2'b00} +: 4];
`endif

        if (lit_s) begin
            an_nxt_s  = ~(8'h01 << idx_r);
            ssd_nxt_s = seg7_encode(nib_s);
            odp_nxt_s = ~top_port_idp;
        end else begin
            an_nxt_s  = 8'hFF;
            ssd_nxt_s = 7'h7F;
            odp_nxt_s = 1'b1;
        end
    end

    // Output register: reset shows digit 0 as "0" with the decimal point off.
    always_ff @(posedge top_port_clk) begin
        if (top_port_rst) begin
            top_port_an  <= 8'hFE;
            top_port_ssd <= 7'h40;
            top_port_odp <= 1'b1;
        end else begin
            top_port_an  <= an_nxt_s;
            top_port_ssd <= ssd_nxt_s;
            top_port_odp <= odp_nxt_s;
        end
    end

endmodule

// File: tb/tb_up_counter_top.sv
// Testbench for up_counter_top (SIZE=1, SCAN_DIV=0 so the digit scan advances
// every cycle). A behavioural model predicts every registered output cycle;
// a vector table of runs then reads the displayed count back off the scan and
// compares it with hand-computed values.

module tb_up_counter_top;

    localparam int SIZE     = 1;
    localparam int SCAN_DIV = 0;

    localparam int ACT_NONE = 0;
    localparam int ACT_RST  = 1;
    localparam int ACT_LOAD = 2;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sel;
    logic       idp;
    logic [6:0] ssd;
    logic       odp;
    logic [7:0] an;

    up_counter_top #(
        .SIZE     (SIZE),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .top_port_clk (clk),
        .top_port_rst (rst),
        .top_port_en  (en),
        .top_port_sel (sel),
        .top_port_idp (idp),
        .top_port_ssd (ssd),
        .top_port_odp (odp),
        .top_port_an  (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          act;
        int          run;
        logic        en;
        logic        sel;
        logic        idp;
        logic [15:0] exp_val;
    } vec_t;

    localparam int NVEC = 16;
    vec_t tbl [NVEC];

    // model state
    int m_presc;
    int m_bin;
    int m_bcd;
    int m_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    function automatic logic [15:0] dec_to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One clock with full output prediction from the pre-edge model state.
    task automatic step();
        logic [15:0] pri;
        logic [3:0]  nib;
        logic [7:0]  an_e;
        logic [15:0] exp_out;
        int          d;
`ifdef SECONDARY_DISPLAY_EN
        logic [15:0] sec;
`endif
        d    = m_idx;
        pri  = sel ? dec_to_bcd(m_bcd) : 16'(m_bin);
        an_e = ~(8'h01 << d);
`ifdef SECONDARY_DISPLAY_EN
        sec  = sel ? 16'(m_bin) : dec_to_bcd(m_bcd);
`endif
        if (rst) begin
            exp_out = {8'hFE, 7'h40, 1'b1};
        end else if (d < 4) begin
            nib     = pri[d*4 +: 4];
            exp_out = {an_e, SEG_TAB[nib], ~idp};
        end else begin
`ifdef SECONDARY_DISPLAY_EN
            nib     = sec[(d-4)*4 +: 4];
            exp_out = {an_e, SEG_TAB[nib], ~idp};
`else
            exp_out = {8'hFF, 7'h7F, 1'b1};
`endif
        end

        if (rst) begin
            m_presc = 0;
            m_bin   = 0;
            m_bcd   = 0;
            m_idx   = 0;
        end else begin
            if (en) begin
                if (m_presc == (1 << SIZE) - 1) begin
                    m_bin = (m_bin + 1) % 65536;
                    m_bcd = (m_bcd + 1) % 10000;
                end
                m_presc = (m_presc + 1) % (1 << SIZE);
            end
            m_idx = (m_idx + 1) % 8;
        end

        @(posedge clk);
        #1;
        cyc++;
        n_cmp++;
        if ({an, ssd, odp} !== exp_out) begin
            n_bad++;
            $display("FAIL disp cyc=%0d got an=%h ssd=%h odp=%b want an=%h ssd=%h odp=%b",
                     cyc, an, ssd, odp, exp_out[15:8], exp_out[7:1], exp_out[0]);
        end
    endtask

    // Freeze counting and read the four lower digits back off the scan.
    task automatic scan_read(output logic [15:0] got);
        en  = 1'b0;
        got = 16'hxxxx;
        for (int s = 0; s < 8; s++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (an == ~(8'h01 << k)) begin
                    for (int j = 0; j < 16; j++) begin
                        if (SEG_TAB[j] == ssd) begin
                            got[k*4 +: 4] = 4'(j);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        logic [15:0] got;

        rst = 1'b1;
        en  = 1'b0;
        sel = 1'b0;
        idp = 1'b0;
        m_presc = 0;
        m_bin   = 0;
        m_bcd   = 0;
        m_idx   = 0;

        //          act       run  en    sel   idp   expected displayed count
        tbl[0]  = '{ACT_RST,  40,  1'b1, 1'b0, 1'b0, 16'h0014};
        tbl[1]  = '{ACT_NONE, 0,   1'b0, 1'b1, 1'b0, 16'h0020};
        tbl[2]  = '{ACT_NONE, 40,  1'b1, 1'b1, 1'b0, 16'h0040};
        tbl[3]  = '{ACT_NONE, 0,   1'b0, 1'b0, 1'b0, 16'h0028};
        tbl[4]  = '{ACT_NONE, 20,  1'b0, 1'b0, 1'b0, 16'h0028};
        tbl[5]  = '{ACT_NONE, 7,   1'b1, 1'b0, 1'b1, 16'h002B};
        tbl[6]  = '{ACT_NONE, 0,   1'b0, 1'b1, 1'b1, 16'h0043};
        tbl[7]  = '{ACT_NONE, 13,  1'b1, 1'b0, 1'b0, 16'h0032};
        tbl[8]  = '{ACT_NONE, 201, 1'b1, 1'b1, 1'b0, 16'h0150};
        tbl[9]  = '{ACT_NONE, 0,   1'b0, 1'b0, 1'b0, 16'h0096};
        tbl[10] = '{ACT_RST,  3,   1'b1, 1'b0, 1'b0, 16'h0001};
        tbl[11] = '{ACT_NONE, 0,   1'b0, 1'b1, 1'b0, 16'h0001};
        tbl[12] = '{ACT_LOAD, 0,   1'b0, 1'b0, 1'b0, 16'hFFFF};
        tbl[13] = '{ACT_NONE, 0,   1'b0, 1'b1, 1'b1, 16'h9999};
        tbl[14] = '{ACT_NONE, 1,   1'b1, 1'b0, 1'b1, 16'h0000};
        tbl[15] = '{ACT_NONE, 0,   1'b0, 1'b1, 1'b0, 16'h0000};

        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].act == ACT_RST) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end else if (tbl[i].act == ACT_LOAD) begin
                // Preload just below both wrap points with the prescaler at its top value.
                force dut.bin_r   = 16'hFFFF;
                force dut.bcd_r   = 16'h9999;
                force dut.presc_r = 1'b1;
                #1;
                release dut.bin_r;
                release dut.bcd_r;
                release dut.presc_r;
                m_bin   = 65535;
                m_bcd   = 9999;
                m_presc = (1 << SIZE) - 1;
            end
            en  = tbl[i].en;
            sel = tbl[i].sel;
            idp = tbl[i].idp;
            for (int c = 0; c < tbl[i].run; c++) begin
                step();
            end
            scan_read(got);
            n_cmp++;
            if (got !== tbl[i].exp_val) begin
                n_bad++;
                $display("FAIL count vec=%0d sel=%b got %h want %h",
                         i, sel, got, tbl[i].exp_val);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
